decode_regread: RTL
===================

DECODE_REGREAD -- requirements
Module: decode_regread

Interface
REQ-001 SHALL have parameter: DATA_W, default 64, register data width.
REQ-002 SHALL have parameter: NREGS, default 15, architectural registers 0..14; ID 15 = RNONE.
REQ-003 SHALL have ports, one per line, in this order:
  clock  in  1  single clock; all state updates on rising edge
  reset_n  in  1  synchronous, active-low reset
  in_valid  in  1  fetch offers instruction fields this cycle
  in_ready  out  1  block can accept instruction this cycle
  in_code  in  4  icode
  ra  in  4  rA field
  rb  in  4  rB field
  wb_en_e  in  1  writeback E-port write enable
  wb_dst_e  in  4  E-port destination register
  wb_val_e  in  DATA_W  E-port write data
  wb_en_m  in  1  writeback M-port write enable
  wb_dst_m  in  4  M-port destination register
  wb_val_m  in  DATA_W  M-port write data
  out_valid  out  1  decoded operands valid
  out_ready  in  1  execute accepts operands
  src_a, src_b  out  4  decoded source register IDs
  dst_e, dst_m  out  4  decoded destination register IDs
  val_a, val_b  out  DATA_W  operand values read for src_a/src_b

Function
REQ-004 SHALL decode src_a: icode 2,4,6,A -> ra; 9,B -> 4 (%rsp); else 15.
REQ-005 SHALL decode src_b: icode 4,5,6 -> rb; 8,9,A,B -> 4; else 15.
REQ-006 SHALL decode dst_e: icode 2,3,6 -> rb; 8,9,A,B -> 4; else 15. Condition gating for icode 2 is not applied here.
REQ-007 SHALL decode dst_m: icode 5,B -> ra; else 15.
REQ-008 SHALL hold 15 x DATA_W registers, written on the rising edge when a port's enable is high and its destination is not 15.
REQ-009 SHALL ignore writes to register 15; reads of 15 SHALL return 0.
REQ-010 SHALL, when E and M ports write the same register in one cycle, store wb_val_m (M wins).
REQ-011 SHALL drive in_ready = !out_valid || out_ready (combinational).
REQ-012 SHALL accept an instruction when in_valid && in_ready; on that edge it registers src/dst IDs and val_a/val_b, and sets out_valid = 1. Latency is 1 cycle.
REQ-013 SHALL bypass same-cycle writes: if a register being read is written on the accept edge, val_a/val_b SHALL capture the new value. Priority is the M value, then the E value, then array contents.
REQ-014 SHALL hold all outputs stable while out_valid && !out_ready. Later writes to a captured source SHALL NOT alter the held val_a/val_b.
REQ-015 SHALL clear out_valid after out_valid && out_ready with no new accept. Accept and drain in the same cycle SHALL replace the outputs, with no bubble.
REQ-016 SHALL process register-file writes independently of the handshake, every cycle, including while stalled.
REQ-017 SHALL treat an unlisted icode (0,1,7,C-F) as a valid token with all IDs 15 and values 0.

Reset
REQ-018 SHALL, on a rising edge with reset_n = 0, clear all 15 registers to 0.
REQ-019 SHALL, on reset, set out_valid = 0; src_a, src_b, dst_e and dst_m = 15; val_a and val_b = 0.
REQ-020 SHALL, on reset, take precedence over a concurrent accept and over writeback writes. A pending stalled output SHALL be discarded.
REQ-021 SHALL drive in_ready = 1 in the first cycle after reset is released.

Structure
REQ-022 SHALL use a shared package y86_pkg for icode constants (IHALT..IPOPQ), RNONE = 4'hF, RRSP = 4'h4, and the register-ID typedef.
REQ-023 SHALL instantiate one sub-module, regfile_2r2w: 15 x DATA_W array with 2 async read ports, 2 write ports, M-priority, and RNONE handling. Bypass, decode and the output register SHALL reside in decode_regread.

Verification
REQ-024 SHALL cover: reset, then irmovq write via wb_en_e=1, wb_dst_e=3, wb_val_e=0x10; next cycle accept opq (6, ra=3, rb=3) -> val_a = val_b = 0x10, dst_e = 3.
REQ-025 SHALL cover: same-cycle bypass: accept pushq (A, ra=2) while wb_en_m=1, wb_dst_m=2, wb_val_m=0x55 -> val_a = 0x55, src_b = 4, dst_e = 4.
REQ-026 SHALL cover: dual-write collision: wb_dst_e = wb_dst_m = 4, val_e = 0x100, val_m = 0x200; then read src 4 -> 0x200.
REQ-027 SHALL cover: stall: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged despite a write to the captured source; when out_ready=1, the next token is loaded on the same edge.
REQ-028 SHALL cover: RNONE: write wb_dst_e=15, val=0xFF; accept irmovq (3, rb=5) -> src_a = src_b = 15, val_a = val_b = 0, dst_e = 5.
REQ-029 SHALL cover: reset_n=0 while out_valid=1 stalled -> next cycle out_valid=0, all registers read 0, IDs = 15.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, special register IDs and the
// register-ID type used by decode and the register file.
package y86_pkg;

    typedef logic [3:0] reg_id_t;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam reg_id_t RNONE = 4'hF;
    localparam reg_id_t RRSP  = 4'h4;

endpackage

// File: rtl/decode_regread_if.sv
// Register-file access bundle: two write ports (E, M) and two async read ports.
interface decode_regread_if
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) ();

    logic              we_e;
    reg_id_t           wdst_e;
    logic [DATA_W-1:0] wval_e;
    logic              we_m;
    reg_id_t           wdst_m;
    logic [DATA_W-1:0] wval_m;
    reg_id_t           raddr_a;
    reg_id_t           raddr_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;

    modport master (
        output we_e, wdst_e, wval_e, we_m, wdst_m, wval_m, raddr_a, raddr_b,
        input  rdata_a, rdata_b
    );

    modport slave (
        input  we_e, wdst_e, wval_e, we_m, wdst_m, wval_m, raddr_a, raddr_b,
        output rdata_a, rdata_b
    );

endinterface

// File: rtl/regfile_2r2w.sv
// Architectural register file: 2 async reads, 2 writes with M-port priority.
// ID RNONE is never stored and always reads as zero.
module regfile_2r2w
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NREGS  = 15
) (
    input logic              clock,
    input logic              reset_n,
    decode_regread_if.slave  rf
);

    logic [DATA_W-1:0] r_regs [NREGS];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            // M write is issued last so it wins on a shared destination
            if (rf.we_e && rf.wdst_e != RNONE && 32'(rf.wdst_e) < NREGS) begin
                r_regs[rf.wdst_e] <= rf.wval_e;
            end
            if (rf.we_m && rf.wdst_m != RNONE && 32'(rf.wdst_m) < NREGS) begin
                r_regs[rf.wdst_m] <= rf.wval_m;
            end
        end
    end

    always_comb begin
        rf.rdata_a = '0;
        rf.rdata_b = '0;
        if (rf.raddr_a != RNONE && 32'(rf.raddr_a) < NREGS) rf.rdata_a = r_regs[rf.raddr_a];
        if (rf.raddr_b != RNONE && 32'(rf.raddr_b) < NREGS) rf.rdata_b = r_regs[rf.raddr_b];
    end

endmodule

// File: rtl/decode_regread.sv
// Y86-64 decode/register-read stage: decodes register IDs, reads operands with
// same-cycle writeback bypass, and holds them in a valid/ready output register.
module decode_regread
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NREGS  = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_code,
    input  logic [3:0]        ra,
    input  logic [3:0]        rb,
    input  logic              wb_en_e,
    input  logic [3:0]        wb_dst_e,
    input  logic [DATA_W-1:0] wb_val_e,
    input  logic              wb_en_m,
    input  logic [3:0]        wb_dst_m,
    input  logic [DATA_W-1:0] wb_val_m,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        src_a,
    output logic [3:0]        src_b,
    output logic [3:0]        dst_e,
    output logic [3:0]        dst_m,
    output logic [DATA_W-1:0] val_a,
    output logic [DATA_W-1:0] val_b
);

    reg_id_t           w_src_a, w_src_b, w_dst_e, w_dst_m;
    logic [DATA_W-1:0] w_val_a, w_val_b;
    logic              w_accept;

    logic              r_out_valid;
    reg_id_t           r_src_a, r_src_b, r_dst_e, r_dst_m;
    logic [DATA_W-1:0] r_val_a, r_val_b;

    decode_regread_if #(.DATA_W(DATA_W)) w_rf ();

    assign w_rf.we_e    = wb_en_e;
    assign w_rf.wdst_e  = wb_dst_e;
    assign w_rf.wval_e  = wb_val_e;
    assign w_rf.we_m    = wb_en_m;
    assign w_rf.wdst_m  = wb_dst_m;
    assign w_rf.wval_m  = wb_val_m;
    assign w_rf.raddr_a = w_src_a;
    assign w_rf.raddr_b = w_src_b;

    regfile_2r2w #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clock   (clock),
        .reset_n (reset_n),
        .rf      (w_rf.slave)
    );

    always_comb begin
        w_src_a = RNONE;
        w_src_b = RNONE;
        w_dst_e = RNONE;
        w_dst_m = RNONE;
        case (in_code)
            IRRMOVQ: begin w_src_a = ra;   w_dst_e = rb; end
            IIRMOVQ: begin w_dst_e = rb; end
            IRMMOVQ: begin w_src_a = ra;   w_src_b = rb; end
            IMRMOVQ: begin w_src_b = rb;   w_dst_m = ra; end
            IOPQ:    begin w_src_a = ra;   w_src_b = rb;   w_dst_e = rb; end
            ICALL:   begin w_src_b = RRSP; w_dst_e = RRSP; end
            IRET:    begin w_src_a = RRSP; w_src_b = RRSP; w_dst_e = RRSP; end
            IPUSHQ:  begin w_src_a = ra;   w_src_b = RRSP; w_dst_e = RRSP; end
            IPOPQ:   begin w_src_a = RRSP; w_src_b = RRSP; w_dst_e = RRSP; w_dst_m = ra; end
            default: ;
        endcase
    end

    // Writes landing on the accept edge are forwarded; M outranks E
    always_comb begin
        w_val_a = w_rf.rdata_a;
        w_val_b = w_rf.rdata_b;
        if (w_src_a != RNONE) begin
            if (wb_en_m && wb_dst_m == w_src_a)      w_val_a = wb_val_m;
            else if (wb_en_e && wb_dst_e == w_src_a) w_val_a = wb_val_e;
        end
        if (w_src_b != RNONE) begin
            if (wb_en_m && wb_dst_m == w_src_b)      w_val_b = wb_val_m;
            else if (wb_en_e && wb_dst_e == w_src_b) w_val_b = wb_val_e;
        end
    end

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_src_a     <= RNONE;
            r_src_b     <= RNONE;
            r_dst_e     <= RNONE;
            r_dst_m     <= RNONE;
            r_val_a     <= '0;
            r_val_b     <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_src_a     <= w_src_a;
            r_src_b     <= w_src_b;
            r_dst_e     <= w_dst_e;
            r_dst_m     <= w_dst_m;
            r_val_a     <= w_val_a;
            r_val_b     <= w_val_b;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign src_a     = r_src_a;
    assign src_b     = r_src_b;
    assign dst_e     = r_dst_e;
    assign dst_m     = r_dst_m;
    assign val_a     = r_val_a;
    assign val_b     = r_val_b;

endmodule
